// File: rtl/spi_transaction_sequencer_if.sv
// Handshake bundle between the SPI byte shifters, the image buffer and the network.
// The sequencer uses the slave view; the surrounding SPI/network logic uses the master view.
interface spi_transaction_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              SS;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              network_done;
  logic [3:0]        detected_digit;
  logic              cost_ready;
  logic [7:0]        cost_output;
  logic              pix_wr;
  logic [ADDR_W-1:0] pix_addr;
  logic [7:0]        pix_data;
  logic [9:0]        expected_label;
  logic              net_start;
  logic [7:0]        tx_byte;

  modport master (
    output SS, rx_valid, rx_byte, network_done, detected_digit, cost_ready, cost_output,
    input  pix_wr, pix_addr, pix_data, expected_label, net_start, tx_byte
  );

  modport slave (
    input  SS, rx_valid, rx_byte, network_done, detected_digit, cost_ready, cost_output,
    output pix_wr, pix_addr, pix_data, expected_label, net_start, tx_byte
  );
endinterface

// File: rtl/spi_transaction_sequencer.sv
// Command-level controller: decodes SPI command bytes, streams pixels into the image
// buffer, latches the expected label, starts the network and builds MISO responses.
module spi_transaction_sequencer #(
  parameter int NUM_PIXELS = 784,
  parameter int ADDR_W     = 10
) (
  input logic clk,
  input logic n_rst,
  spi_transaction_sequencer_if.slave bus
);

  localparam logic [1:0] WAIT_CMD = 2'd0;
  localparam logic [1:0] LOAD_PIX = 2'd1;
  localparam logic [1:0] LOAD_LBL = 2'd2;
  localparam logic [1:0] RESPOND  = 2'd3;

  localparam logic [7:0] CMD_LOAD_IMAGE  = 8'h01;
  localparam logic [7:0] CMD_LOAD_LABEL  = 8'h02;
  localparam logic [7:0] CMD_START       = 8'h03;
  localparam logic [7:0] CMD_READ_STATUS = 8'h04;
  localparam logic [7:0] CMD_READ_COST   = 8'h05;
  localparam logic [7:0] CMD_READ_DIGIT  = 8'h06;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  logic [1:0]        state_q, state_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic              pix_wr_q, pix_wr_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [7:0]        pix_data_q, pix_data_d;
  logic [9:0]        label_q, label_d;
  logic              net_start_q, net_start_d;
  logic              busy_q, busy_d;
  logic              res_valid_q, res_valid_d;
  logic              cost_valid_q, cost_valid_d;
  logic              img_ok_q, img_ok_d;
  logic              err_q, err_d;
  logic [3:0]        digit_q, digit_d;
  logic [7:0]        cost_q, cost_d;

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    pix_cnt_d    = pix_cnt_q;
    pix_wr_d     = 1'b0;
    pix_addr_d   = pix_addr_q;
    pix_data_d   = pix_data_q;
    label_d      = label_q;
    net_start_d  = 1'b0;
    busy_d       = busy_q;
    res_valid_d  = res_valid_q;
    cost_valid_d = cost_valid_q;
    img_ok_d     = img_ok_q;
    err_d        = err_q;
    digit_d      = digit_q;
    cost_d       = cost_q;

    // Network events land first so a START decoded in the same cycle sees busy already
    // released and its own clears of res_valid/cost_valid take precedence.
    if (bus.network_done) begin
      digit_d     = bus.detected_digit;
      res_valid_d = 1'b1;
      busy_d      = 1'b0;
    end
    if (bus.cost_ready) begin
      cost_d       = bus.cost_output;
      cost_valid_d = 1'b1;
    end

    if (bus.SS) begin
      state_d = WAIT_CMD;
      tx_d    = 8'hFF;
    end else if (bus.rx_valid) begin
      case (state_q)
        LOAD_PIX: begin
          pix_wr_d   = 1'b1;
          pix_addr_d = pix_cnt_q;
          pix_data_d = bus.rx_byte;
          if (pix_cnt_q == LAST_PIX) begin
            img_ok_d  = 1'b1;
            pix_cnt_d = '0;
            state_d   = WAIT_CMD;
          end else begin
            pix_cnt_d = pix_cnt_q + ADDR_W'(1);
          end
        end
        LOAD_LBL: begin
          if (bus.rx_byte <= 8'd9) begin
            label_d = 10'd1 << bus.rx_byte[3:0];
          end else begin
            label_d = '0;
            err_d   = 1'b1;
          end
          state_d = WAIT_CMD;
        end
        default: begin
          tx_d    = 8'hFF;
          state_d = WAIT_CMD;
          case (bus.rx_byte)
            CMD_LOAD_IMAGE: begin
              pix_cnt_d = '0;
              img_ok_d  = 1'b0;
              state_d   = LOAD_PIX;
            end
            CMD_LOAD_LABEL: state_d = LOAD_LBL;
            CMD_START: begin
              if (img_ok_q && !busy_d) begin
                net_start_d  = 1'b1;
                busy_d       = 1'b1;
                res_valid_d  = 1'b0;
                cost_valid_d = 1'b0;
              end else begin
                err_d = 1'b1;
              end
            end
            CMD_READ_STATUS: begin
              tx_d    = {busy_q, res_valid_q, cost_valid_q, img_ok_q, err_q, 3'b000};
              err_d   = 1'b0;
              state_d = RESPOND;
            end
            CMD_READ_COST: begin
              tx_d    = cost_valid_q ? cost_q : 8'hFF;
              state_d = RESPOND;
            end
            CMD_READ_DIGIT: begin
              tx_d    = res_valid_q ? {4'h0, digit_q} : 8'hFF;
              state_d = RESPOND;
            end
            default: err_d = 1'b1;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= WAIT_CMD;
      tx_q         <= 8'hFF;
      pix_cnt_q    <= '0;
      pix_wr_q     <= 1'b0;
      pix_addr_q   <= '0;
      pix_data_q   <= '0;
      label_q      <= '0;
      net_start_q  <= 1'b0;
      busy_q       <= 1'b0;
      res_valid_q  <= 1'b0;
      cost_valid_q <= 1'b0;
      img_ok_q     <= 1'b0;
      err_q        <= 1'b0;
      digit_q      <= '0;
      cost_q       <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      pix_cnt_q    <= pix_cnt_d;
      pix_wr_q     <= pix_wr_d;
      pix_addr_q   <= pix_addr_d;
      pix_data_q   <= pix_data_d;
      label_q      <= label_d;
      net_start_q  <= net_start_d;
      busy_q       <= busy_d;
      res_valid_q  <= res_valid_d;
      cost_valid_q <= cost_valid_d;
      img_ok_q     <= img_ok_d;
      err_q        <= err_d;
      digit_q      <= digit_d;
      cost_q       <= cost_d;
    end
  end

  assign bus.tx_byte        = tx_q;
  assign bus.pix_wr         = pix_wr_q;
  assign bus.pix_addr       = pix_addr_q;
  assign bus.pix_data       = pix_data_q;
  assign bus.expected_label = label_q;
  assign bus.net_start      = net_start_q;

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Self-checking bench: directed command scenarios plus randomized traffic, all compared
// every cycle against a transaction-level model of the sequencer kept in this file.
module tb_spi_transaction_sequencer;

  localparam int NUM_PIXELS = 784;
  localparam int ADDR_W     = 10;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  spi_transaction_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  spi_transaction_sequencer #(.NUM_PIXELS(NUM_PIXELS), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;
  int pixCount    = 0;
  int netCount    = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      if (failCount <= 40)
        $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: flags, stored results and an "expecting" mode (commands, pixels
  // or label) with a count of pixels already taken; MISO byte only changes on events.
  int  mode;
  int  pixelsTaken;
  bit  mBusy, mResValid, mCostValid, mImgOk, mErr;
  int  mDigit, mCost, mLabel, mTx;
  bit  mPixWr, mNetStart;
  int  mPixAddr, mPixData;
  bit  modelReady = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    int statusByte, costByte, digitByte, b;
    if (!n_rst) begin
      mode = 0; pixelsTaken = 0;
      mBusy = 0; mResValid = 0; mCostValid = 0; mImgOk = 0; mErr = 0;
      mDigit = 0; mCost = 0; mLabel = 0; mTx = 8'hFF;
      mPixWr = 0; mNetStart = 0; mPixAddr = 0; mPixData = 0;
      modelReady = 1'b1;
    end else begin
      statusByte = mBusy * 128 + mResValid * 64 + mCostValid * 32 + mImgOk * 16 + mErr * 8;
      costByte   = mCostValid ? mCost : 255;
      digitByte  = mResValid ? mDigit : 255;
      mPixWr     = 0;
      mNetStart  = 0;
      if (bus.network_done) begin
        mDigit = int'(bus.detected_digit); mResValid = 1; mBusy = 0;
      end
      if (bus.cost_ready) begin
        mCost = int'(bus.cost_output); mCostValid = 1;
      end
      if (bus.SS) begin
        mode = 0; mTx = 255;
      end else if (bus.rx_valid) begin
        b = int'(bus.rx_byte);
        if (mode == 1) begin
          mPixWr = 1; mPixAddr = pixelsTaken; mPixData = b;
          pixelsTaken++;
          if (pixelsTaken == NUM_PIXELS) begin
            mImgOk = 1; mode = 0;
          end
        end else if (mode == 2) begin
          if (b < 10) mLabel = 1 << b;
          else begin mLabel = 0; mErr = 1; end
          mode = 0;
        end else begin
          mTx = 255;
          case (b)
            1: begin mode = 1; pixelsTaken = 0; mImgOk = 0; end
            2: mode = 2;
            3: begin
              if (mImgOk && !mBusy) begin
                mNetStart = 1; mBusy = 1; mResValid = 0; mCostValid = 0;
              end else mErr = 1;
            end
            4: begin mTx = statusByte; mErr = 0; end
            5: mTx = costByte;
            6: mTx = digitByte;
            default: mErr = 1;
          endcase
        end
      end
    end
  end

  // Per-cycle compare of every registered output against the model.
  always @(negedge clk) begin
    if (modelReady && n_rst) begin
      if (bus.pix_wr) pixCount++;
      if (bus.net_start) netCount++;
      checkOutput("tx_byte", int'(bus.tx_byte), mTx);
      checkOutput("pix_wr", int'(bus.pix_wr), int'(mPixWr));
      checkOutput("net_start", int'(bus.net_start), int'(mNetStart));
      checkOutput("expected_label", int'(bus.expected_label), mLabel);
      if (mPixWr) begin
        checkOutput("pix_addr", int'(bus.pix_addr), mPixAddr);
        checkOutput("pix_data", int'(bus.pix_data), mPixData);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulseNet(input bit nd, input logic [3:0] dig, input bit cr, input logic [7:0] cost);
    @(negedge clk);
    bus.network_done   = nd;
    bus.detected_digit = dig;
    bus.cost_ready     = cr;
    bus.cost_output    = cost;
    @(negedge clk);
    bus.network_done = 1'b0;
    bus.cost_ready   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic readStatus(input string name, input int expected);
    applyStimulus(8'h04);
    checkOutput(name, int'(bus.tx_byte), expected);
  endtask

  initial begin
    bus.SS = 1'b0; bus.rx_valid = 1'b0; bus.rx_byte = '0;
    bus.network_done = 1'b0; bus.detected_digit = '0;
    bus.cost_ready = 1'b0; bus.cost_output = '0;

    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    idle(2);
    checkOutput("reset tx_byte", int'(bus.tx_byte), 8'hFF);

    readStatus("status after reset", 8'h00);
    applyStimulus(8'h05);
    checkOutput("cost without result", int'(bus.tx_byte), 8'hFF);

    netCount = 0;
    applyStimulus(8'h03);
    idle(1);
    checkOutput("start without image pulses", netCount, 0);
    readStatus("status err after bad start", 8'h08);
    readStatus("status err cleared", 8'h00);

    pixCount = 0;
    applyStimulus(8'h01);
    for (int i = 0; i < NUM_PIXELS; i++) applyStimulus(8'(i % 256));
    checkOutput("last pix_addr", int'(bus.pix_addr), 783);
    checkOutput("last pix_data", int'(bus.pix_data), 8'h0F);
    idle(1);
    checkOutput("pix_wr pulse count", pixCount, NUM_PIXELS);
    readStatus("status image loaded", 8'h10);

    applyStimulus(8'h02); applyStimulus(8'd7);
    checkOutput("label 7", int'(bus.expected_label), 10'b0010000000);
    applyStimulus(8'h02); applyStimulus(8'd12);
    checkOutput("label 12", int'(bus.expected_label), 0);
    readStatus("status label err", 8'h18);
    readStatus("status label err cleared", 8'h10);

    netCount = 0;
    applyStimulus(8'h03);
    idle(2);
    checkOutput("start pulse count", netCount, 1);
    readStatus("status busy", 8'h90);
    applyStimulus(8'h03);
    idle(2);
    checkOutput("start while busy pulses", netCount, 1);
    readStatus("status busy err", 8'h98);
    pulseNet(1'b0, 4'd0, 1'b1, 8'd133);
    pulseNet(1'b1, 4'd7, 1'b0, 8'd0);
    applyStimulus(8'h05);
    checkOutput("read cost", int'(bus.tx_byte), 8'h85);
    applyStimulus(8'h06);
    checkOutput("read digit", int'(bus.tx_byte), 8'h07);
    readStatus("status results", 8'h70);

    applyStimulus(8'h03);
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_byte = 8'h03;
    bus.network_done = 1'b1; bus.detected_digit = 4'd5;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.network_done = 1'b0;
    checkOutput("start with done pulses", int'(bus.net_start), 1);
    readStatus("status done+start", 8'h90);
    pulseNet(1'b1, 4'd2, 1'b0, 8'd0);
    @(negedge clk);
    bus.rx_valid = 1'b1; bus.rx_byte = 8'h03;
    bus.cost_ready = 1'b1; bus.cost_output = 8'h42;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.cost_ready = 1'b0;
    readStatus("status cost+start", 8'h90);
    applyStimulus(8'h06);
    checkOutput("digit cleared by start", int'(bus.tx_byte), 8'hFF);

    pulseNet(1'b1, 4'd9, 1'b0, 8'd0);
    applyStimulus(8'h06);
    checkOutput("digit 9", int'(bus.tx_byte), 8'h09);
    @(negedge clk); bus.SS = 1'b1;
    @(negedge clk); bus.rx_valid = 1'b1; bus.rx_byte = 8'h04;
    @(negedge clk); bus.rx_valid = 1'b0; bus.SS = 1'b0;
    checkOutput("tx after SS high", int'(bus.tx_byte), 8'hFF);
    applyStimulus(8'h01);
    for (int i = 0; i < 100; i++) applyStimulus(8'($urandom_range(255)));
    @(negedge clk); bus.SS = 1'b1;
    @(negedge clk); bus.SS = 1'b0;
    checkOutput("tx after partial load", int'(bus.tx_byte), 8'hFF);
    readStatus("status partial load", 8'h40);

    for (int c = 0; c < 6000; c++) begin
      int r;
      @(negedge clk);
      r = int'($urandom_range(999));
      bus.SS = (mode == 1) ? (r < 1) : (r < 30);
      bus.rx_valid = ($urandom_range(99) < 45);
      r = int'($urandom_range(99));
      if (r < 4) bus.rx_byte = 8'h01;
      else if (r < 75) bus.rx_byte = 8'($urandom_range(6, 2));
      else bus.rx_byte = 8'($urandom_range(255));
      bus.network_done   = ($urandom_range(99) < 5);
      bus.detected_digit = 4'($urandom_range(15));
      bus.cost_ready     = ($urandom_range(99) < 5);
      bus.cost_output    = 8'($urandom_range(255));
    end
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.network_done = 1'b0; bus.cost_ready = 1'b0; bus.SS = 1'b1;
    @(negedge clk); bus.SS = 1'b0;

    applyStimulus(8'h01);
    for (int i = 0; i < 50; i++) applyStimulus(8'(i + 1));
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("async reset tx_byte", int'(bus.tx_byte), 8'hFF);
    checkOutput("async reset pix_wr", int'(bus.pix_wr), 0);
    checkOutput("async reset pix_addr", int'(bus.pix_addr), 0);
    checkOutput("async reset pix_data", int'(bus.pix_data), 0);
    checkOutput("async reset label", int'(bus.expected_label), 0);
    checkOutput("async reset net_start", int'(bus.net_start), 0);
    repeat (2) @(posedge clk);
    #2 n_rst = 1'b1;
    readStatus("status after async reset", 8'h00);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
